// File: rtl/id_operand_scoreboard_pkg.sv
// Shared types and helpers for the ID-stage operand scoreboard.
package id_operand_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;

    // One in-flight register writer tracked by the scoreboard.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_load;
    } sb_entry_t;

    // Width of a per-port forward select: 0 = register file, k+1 = stage k.
    function automatic int fwd_sel_w(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/id_operand_port.sv
// One read port: youngest-match search over the scoreboard, readiness
// check, operand mux and stall request.
module id_operand_port
    import id_operand_scoreboard_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STAGES      = 3,
    parameter int FWD_FROM_EX = 0,
    parameter int LOAD_READY  = 2,
    parameter int SEL_W       = 2
) (
    input  sb_entry_t [STAGES-1:0]   entries,
    input  logic [REG_ADDR_W-1:0]    rs_addr,
    input  logic                     rs_used,
    input  logic [XLEN-1:0]          rf_data,
    input  logic [STAGES*XLEN-1:0]   stage_data,
    output logic [SEL_W-1:0]         sel,
    output logic [XLEN-1:0]          data,
    output logic                     stall_req
);

    // Earliest stage at which a non-load result can be forwarded.
    localparam int ALU_READY = (FWD_FROM_EX != 0) ? 0 : 1;

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        sel       = '0;
        data      = rf_data;
        stall_req = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (entries[k].valid && (entries[k].rd == rs_addr) &&
                rs_used && (rs_addr != '0)) begin
                sel       = SEL_W'(k + 1);
                data      = stage_data[k*XLEN +: XLEN];
                stall_req = entries[k].is_load ? (k < LOAD_READY) : (k < ALU_READY);
            end
        end
    end

endmodule

// File: rtl/id_operand_scoreboard.sv
// ID-stage operand scoreboard: tracks in-flight writers per post-ID stage,
// drives per-port forwarding and a combined stall, and counts stall cycles.
module id_operand_scoreboard
    import id_operand_scoreboard_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_RD      = 2,
    parameter int STAGES      = 3,
    parameter int FWD_FROM_EX = 0,
    parameter int LOAD_READY  = 2,
    parameter int CNT_W       = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  pipe_advance,
    input  logic                                  flush,
    input  logic                                  issue_valid,
    input  logic                                  issue_regwrite,
    input  logic                                  issue_is_load,
    input  logic [4:0]                            issue_rd,
    input  logic [NUM_RD*5-1:0]                   rs_addr,
    input  logic [NUM_RD-1:0]                     rs_used,
    input  logic [NUM_RD*XLEN-1:0]                rf_data,
    input  logic [STAGES*XLEN-1:0]                stage_data,
    output logic [NUM_RD*$clog2(STAGES+1)-1:0]    fwd_sel,
    output logic [NUM_RD*XLEN-1:0]                fwd_data,
    output logic                                  stall,
    output logic [CNT_W-1:0]                      stall_cnt
);

    localparam int SEL_W = fwd_sel_w(STAGES);

    sb_entry_t [STAGES-1:0] sb_reg;
    sb_entry_t              entry0_next;
    logic [NUM_RD-1:0]      stall_req;
    logic [CNT_W-1:0]       stall_cnt_reg;
    logic                   accept;

    // A stalled or squashed instruction must not be recorded as a producer.
    assign accept = issue_valid & issue_regwrite & (issue_rd != 5'd0) & ~stall & ~flush;
    assign stall  = |stall_req;
    assign stall_cnt = stall_cnt_reg;

    // New youngest entry: the accepted writer, otherwise a bubble.
    always_comb begin
        entry0_next = '0;
        if (accept) begin
            entry0_next.valid   = 1'b1;
            entry0_next.rd      = issue_rd;
            entry0_next.is_load = issue_is_load;
        end
    end

    // Scoreboard shift register; moves only with the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_reg <= '0;
        end else if (pipe_advance) begin
            sb_reg[0] <= entry0_next;
            for (int k = 1; k < STAGES; k++) begin
                sb_reg[k] <= sb_reg[k-1];
            end
        end
    end

    // Saturating count of cycles in which a stall actually held the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (stall && pipe_advance && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
            id_operand_port #(
                .XLEN        (XLEN),
                .STAGES      (STAGES),
                .FWD_FROM_EX (FWD_FROM_EX),
                .LOAD_READY  (LOAD_READY),
                .SEL_W       (SEL_W)
            ) u_port (
                .entries    (sb_reg),
                .rs_addr    (rs_addr[gi*5 +: 5]),
                .rs_used    (rs_used[gi]),
                .rf_data    (rf_data[gi*XLEN +: XLEN]),
                .stage_data (stage_data),
                .sel        (fwd_sel[gi*SEL_W +: SEL_W]),
                .data       (fwd_data[gi*XLEN +: XLEN]),
                .stall_req  (stall_req[gi])
            );
        end
    endgenerate

endmodule
